fc_vec_serializer: RTL

- Parallel-to-serial converter between FC layers.
- Captures the DIM-element neuron output vector, which arrives on one in_valid pulse.
- Streams the vector out one element per slot on an out_dat/out_valid pair, matching the serial input of the next FC layer.
- Double-buffered, so a new vector can be accepted while the previous one is still streaming. Widens each element to the next layer's input width.

---
 rtl/fc_vec_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fc_vec_serializer.sv
// Parallel-to-serial converter between FC layers: captures a DIM-element vector on one strobe and
// streams it out element by element, widened, with a one-deep pending buffer behind the active one.
module fc_vec_serializer #(
  parameter int unsigned DIM      = 8,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 16,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned GAP      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_dat [DIM],
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_dat,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned       IDX_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [7:0]        GAP_LEN  = 8'(GAP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  if (OUT_W < IN_W) begin : g_bad_width
    $error("OUT_W must be >= IN_W");
  end
  if (GAP > 255) begin : g_bad_gap
    $error("GAP must be in 0..255");
  end

  function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] e);
    if (SIGN_EXT) return OUT_W'($signed(e));
    return OUT_W'(e);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [7:0]       gap_q, gap_d;
  logic [IN_W-1:0]  act_q [DIM];
  logic [IN_W-1:0]  act_d [DIM];
  logic [IN_W-1:0]  pend_q [DIM];
  logic [IN_W-1:0]  pend_d [DIM];
  logic             pend_vld_q, pend_vld_d;
  logic             ovf_d;
  logic             emit, promote, take_in;
  logic [IN_W-1:0]  emit_elem;
  logic             is_last;

  assign is_last = (idx_q == LAST_IDX);
  assign nxt_idx = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = overflow;
    emit       = 1'b0;
    emit_elem  = '0;
    promote    = 1'b0;
    take_in    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          act_d     = in_dat;
          idx_d     = '0;
          emit      = 1'b1;
          emit_elem = in_dat[0];
          take_in   = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (GAP == 0) begin
          if (!is_last) begin
            idx_d     = nxt_idx;
            emit      = 1'b1;
            emit_elem = act_q[nxt_idx];
          end else if (pend_vld_q) begin
            promote = 1'b1;
          end else if (in_valid) begin
            // Nothing pending: a vector arriving on the last element streams on without a bubble.
            act_d     = in_dat;
            idx_d     = '0;
            emit      = 1'b1;
            emit_elem = in_dat[0];
            take_in   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (is_last && !pend_vld_q && !in_valid) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          gap_d   = GAP_LEN;
        end
      end
      WAIT: begin
        if (gap_q == 8'd1) begin
          if (!is_last) begin
            idx_d     = nxt_idx;
            emit      = 1'b1;
            emit_elem = act_q[nxt_idx];
            state_d   = SEND;
          end else if (pend_vld_q) begin
            promote = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (promote) begin
      act_d      = pend_q;
      idx_d      = '0;
      emit       = 1'b1;
      emit_elem  = pend_q[0];
      pend_vld_d = 1'b0;
      state_d    = SEND;
    end

    // A slot freed by promotion this cycle is immediately reusable.
    if (in_valid && (state_q != IDLE) && !take_in) begin
      if (!pend_vld_q || promote) begin
        pend_d     = in_dat;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      act_q      <= '{default: '0};
      pend_q     <= '{default: '0};
      pend_vld_q <= 1'b0;
      out_dat    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_dat    <= emit ? widen(emit_elem) : '0;
      out_valid  <= emit;
      out_last   <= emit && (idx_d == LAST_IDX);
      busy       <= (state_d != IDLE) || pend_vld_d;
      overflow   <= ovf_d;
    end
  end

endmodule
